// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit line driver.
package usb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEopSe0,
        StEopJ
    } tx_state_e;

    // Sent LSB first: seven 0s then a 1, giving K J K J K J K K from idle J.
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Number of consecutive 1 data bits after which a 0 is stuffed.
    localparam int unsigned STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI encoder with bit stuffing. One data bit is presented per bit_stb; when
// stall is high the strobe emits a stuffed 0 instead and bit_in is not consumed.
// The ones counter mirrors what the receive-side unstuffer tracks.
module usb_nrzi_stuffer
    import usb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bit_stb,
    input  logic bit_in,
    output logic line_j,
    output logic stall
);

    logic [2:0] ones_q;

    // Next strobe must carry a stuffed 0 once the run of 1s reaches the limit.
    assign stall = (ones_q == 3'(STUFF_LIMIT));

    // Line state (1 = J) and run length of consecutive 1 data bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_j <= 1'b1;
            ones_q <= '0;
        end else if (clr) begin
            line_j <= 1'b1;
            ones_q <= '0;
        end else if (bit_stb) begin
            if (stall || !bit_in) begin
                line_j <= ~line_j;
                ones_q <= '0;
            end else begin
                ones_q <= ones_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_line.sv
// USB full-speed packet transmitter: SYNC, NRZI/stuffed payload bytes, EOP.
// Each bit time is CLKS_PER_BIT cycles (must be at least 2); the line only
// changes on the edge that ends a bit time, or on the edge leaving IDLE.
module usb_tx_line
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dn,
    output logic       oe,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    shreg_q;
    logic [3:0]    bidx_q;        // bits of the current byte already on the line
    logic          last_q;
    logic          eop_second_q;
    logic          oe_q;
    logic          busy_q;
    logic          underrun_q;

    logic          line_j;
    logic          stall;
    logic          sending;
    logic          strobe;
    logic          start;
    logic          bit_stb;
    logic          bit_in;
    logic          clr;

    assign sending = (state_q == StSync) || (state_q == StData);
    assign strobe  = (state_q != StIdle) && (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign start   = (state_q == StIdle) && tx_valid;

    // Ask for a byte once the current one is fully on the line and no stuff bit
    // is pending, one cycle before the strobe that would present its first bit.
    assign tx_ready = sending && (bidx_q == 4'd8) && !stall && !last_q &&
                      (cnt_q == CW'(CLKS_PER_BIT - 2));

    // The first SYNC bit goes out on the edge leaving IDLE.
    assign bit_stb = start || (sending && strobe && (stall || (bidx_q != 4'd8)));
    assign bit_in  = start ? SYNC_BYTE[0] : shreg_q[0];
    assign clr     = (state_q == StEopJ) && strobe;

    usb_nrzi_stuffer u_stuffer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .bit_stb (bit_stb),
        .bit_in  (bit_in),
        .line_j  (line_j),
        .stall   (stall)
    );

    // Packet sequencing, bit timing, byte shifter and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shreg_q      <= '0;
            bidx_q       <= '0;
            last_q       <= 1'b0;
            eop_second_q <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            underrun_q <= tx_ready && !tx_valid;

            if ((state_q == StIdle) || strobe) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            // Capture never coincides with a strobe, so it cannot race the shift.
            if (tx_ready && tx_valid) begin
                shreg_q <= tx_data;
                bidx_q  <= '0;
                last_q  <= tx_last;
            end

            unique case (state_q)
                StIdle: begin
                    if (tx_valid) begin
                        state_q <= StSync;
                        shreg_q <= SYNC_BYTE >> 1;
                        bidx_q  <= 4'd1;
                        last_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StSync, StData: begin
                    if (strobe && !stall) begin
                        if (bidx_q == 4'd8) begin
                            // Last byte done or no byte supplied: finish the packet.
                            state_q      <= StEopSe0;
                            eop_second_q <= 1'b0;
                        end else begin
                            shreg_q <= shreg_q >> 1;
                            bidx_q  <= bidx_q + 4'd1;
                            if (bidx_q == 4'd0) begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StEopSe0: begin
                    if (strobe) begin
                        if (eop_second_q) begin
                            state_q <= StEopJ;
                        end
                        eop_second_q <= 1'b1;
                    end
                end
                StEopJ: begin
                    if (strobe) begin
                        state_q <= StIdle;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dp       = (state_q == StEopSe0) ? 1'b0 : (sending ? line_j : 1'b1);
    assign dn       = (state_q == StEopSe0) ? 1'b0 : (sending ? ~line_j : 1'b0);
    assign oe       = oe_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_line.sv
// Scoreboard bench for usb_tx_line at 4 and 8 clocks per bit.
module tb_usb_tx_line;

    typedef struct {
        string syms;
        int    readies;
        int    underruns;
        bit    aborted;
    } pkt_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    bit         sel;

    logic v0, v1;
    logic rdy0, dp0, dn0, oe0, busy0, und0;
    logic rdy1, dp1, dn1, oe1, busy1, und1;
    logic tx_ready_m, dp_m, dn_m, oe_m, busy_m, und_m;

    int checks;
    int failures;
    pkt_t exp_q[$];

    assign v0 = tx_valid & ~sel;
    assign v1 = tx_valid & sel;

    usb_tx_line #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (v0),
        .tx_last  (tx_last),
        .tx_ready (rdy0),
        .dp       (dp0),
        .dn       (dn0),
        .oe       (oe0),
        .busy     (busy0),
        .underrun (und0)
    );

    usb_tx_line #(.CLKS_PER_BIT(8)) u_dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (v1),
        .tx_last  (tx_last),
        .tx_ready (rdy1),
        .dp       (dp1),
        .dn       (dn1),
        .oe       (oe1),
        .busy     (busy1),
        .underrun (und1)
    );

    assign tx_ready_m = sel ? rdy1  : rdy0;
    assign dp_m       = sel ? dp1   : dp0;
    assign dn_m       = sel ? dn1   : dn0;
    assign oe_m       = sel ? oe1   : oe0;
    assign busy_m     = sel ? busy1 : busy0;
    assign und_m      = sel ? und1  : und0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string got, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic byte sym(input logic p, input logic n);
        if (p && !n) return "J";
        if (!p && n) return "K";
        if (!p && !n) return "0";
        return "X";
    endfunction

    task automatic expect_pkt(input string s, input int r, input int u, input bit ab);
        pkt_t p;
        p.syms      = s;
        p.readies   = r;
        p.underruns = u;
        p.aborted   = ab;
        exp_q.push_back(p);
    endtask

    // Monitor: pops one expected packet per oe burst and checks it cycle by cycle.
    pkt_t cur;
    bit   in_pkt = 1'b0;
    int   ocyc, nready, nunder, cpb, idx;
    byte  got_s, exp_s;

    always @(negedge clk) begin
        cpb = sel ? 8 : 4;
        if (oe_m && !in_pkt) begin
            in_pkt = 1'b1;
            ocyc   = 0;
            nready = 0;
            nunder = 0;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_packet", "packet", "none");
                cur.syms = ""; cur.readies = 0; cur.underruns = 0; cur.aborted = 1'b1;
            end else begin
                cur = exp_q.pop_front();
            end
        end
        if (in_pkt && oe_m) begin
            idx   = ocyc / cpb;
            got_s = sym(dp_m, dn_m);
            exp_s = (idx < cur.syms.len()) ? cur.syms[idx] : "-";
            check(got_s == exp_s, $sformatf("line bit %0d", idx),
                  $sformatf("%c", got_s), $sformatf("%c", exp_s));
            check(busy_m == 1'b1, "busy_in_packet", $sformatf("%b", busy_m), "1");
            if (tx_ready_m) begin
                nready++;
                check((ocyc % cpb) == (cpb - 2), "ready_phase",
                      $sformatf("%0d", ocyc % cpb), $sformatf("%0d", cpb - 2));
            end
            if (und_m) nunder++;
            ocyc++;
        end else if (in_pkt) begin
            in_pkt = 1'b0;
            if (!cur.aborted) begin
                check(ocyc == cur.syms.len() * cpb, "oe_cycles",
                      $sformatf("%0d", ocyc), $sformatf("%0d", cur.syms.len() * cpb));
                check(nready == cur.readies, "ready_pulses",
                      $sformatf("%0d", nready), $sformatf("%0d", cur.readies));
                check(nunder == cur.underruns, "underrun_pulses",
                      $sformatf("%0d", nunder), $sformatf("%0d", cur.underruns));
            end
            check(dp_m && !dn_m && !busy_m, "idle_after_packet",
                  $sformatf("dp=%b dn=%b busy=%b", dp_m, dn_m, busy_m), "dp=1 dn=0 busy=0");
        end
    end

    // Offer nbytes bytes (d0 then d1), but only the first 'offered' of them.
    task automatic send(input logic [7:0] d0, input logic [7:0] d1,
                        input int nbytes, input int offered);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        @(negedge clk);
        tx_data  = d0;
        tx_last  = (nbytes == 1);
        tx_valid = 1'b1;
        while (sent < offered && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (tx_ready_m) begin
                @(posedge clk);
                #1;
                sent++;
                if (sent < offered) begin
                    tx_data = d1;
                    tx_last = (sent == nbytes - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                    tx_data  = 8'h00;
                end
            end
        end
        if (sent < offered) begin
            tx_valid = 1'b0;
            check(1'b0, "handshake_timeout", $sformatf("%0d", sent), $sformatf("%0d", offered));
        end
        guard = 0;
        while (busy_m && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check(!busy_m, "packet_end_timeout", $sformatf("%b", busy_m), "0");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check(oe_m == 1'b0, "reset_oe", $sformatf("%b", oe_m), "0");
        check(dp_m == 1'b1 && dn_m == 1'b0, "reset_line",
              $sformatf("dp=%b dn=%b", dp_m, dn_m), "dp=1 dn=0");
        check(busy_m == 1'b0 && tx_ready_m == 1'b0 && und_m == 1'b0, "reset_status",
              $sformatf("busy=%b rdy=%b und=%b", busy_m, tx_ready_m, und_m), "all 0");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0x00: every data bit toggles.
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 1, 0, 1'b0);
        send(8'h00, 8'h00, 1, 1);
        // 0xFF: stuff after the fifth data bit.
        expect_pkt({"KJKJKJKK", "KKKKKJJJJ", "00J"}, 1, 0, 1'b0);
        send(8'hFF, 8'h00, 1, 1);
        // 0x3F, 0xC0: run of ones continues from SYNC into the first byte.
        expect_pkt({"KJKJKJKK", "KKKKKJJKJ", "KJKJKJJJ", "00J"}, 2, 0, 1'b0);
        send(8'h3F, 8'hC0, 2, 2);
        // 0xFC, 0x00: stuff bit sits between the bytes, delaying tx_ready.
        expect_pkt({"KJKJKJKK", "JKKKKKKK", "J", "KJKJKJKJ", "00J"}, 2, 0, 1'b0);
        send(8'hFC, 8'h00, 2, 2);
        // Underrun after the first of two bytes.
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 2, 1, 1'b0);
        send(8'h00, 8'h00, 2, 1);

        // Reset in the middle of byte 2.
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "JKJKJKJK", "JKJKJKJK"}, 0, 0, 1'b1);
        @(negedge clk);
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        guard    = 0;
        while (!oe_m && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check(oe_m == 1'b1, "reset_test_start", $sformatf("%b", oe_m), "1");
        repeat (20 * 4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check(oe_m == 1'b0, "midreset_oe", $sformatf("%b", oe_m), "0");
        check(dp_m == 1'b1 && dn_m == 1'b0, "midreset_line",
              $sformatf("dp=%b dn=%b", dp_m, dn_m), "dp=1 dn=0");
        check(busy_m == 1'b0 && tx_ready_m == 1'b0, "midreset_status",
              $sformatf("busy=%b rdy=%b", busy_m, tx_ready_m), "busy=0 rdy=0");
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 1, 0, 1'b0);
        send(8'h00, 8'h00, 1, 1);

        // Same sequences at 8 clocks per bit.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 1, 0, 1'b0);
        send(8'h00, 8'h00, 1, 1);
        expect_pkt({"KJKJKJKK", "KKKKKJJJJ", "00J"}, 1, 0, 1'b0);
        send(8'hFF, 8'h00, 1, 1);
        expect_pkt({"KJKJKJKK", "KKKKKJJKJ", "KJKJKJJJ", "00J"}, 2, 0, 1'b0);
        send(8'h3F, 8'hC0, 2, 2);

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "pending_packets", $sformatf("%0d", exp_q.size()), "0");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_line.md
USB_TX_LINE -- requirements
Module: usb_tx_line

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per USB bit time (48 MHz clk gives 12 Mb/s full speed).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, the packet byte, sent LSB first.
REQ-005 SHALL have port tx_valid, input, 1, meaning tx_data is offered.
REQ-006 SHALL have port tx_last, input, 1, qualifying the offered byte as the final byte of the packet.
REQ-007 SHALL have port tx_ready, output, 1, a one-cycle accept strobe; the byte transfers when tx_valid && tx_ready.
REQ-008 SHALL have port dp, output, 1, the D+ drive level.
REQ-009 SHALL have port dn, output, 1, the D- drive level.
REQ-010 SHALL have port oe, output, 1, the output enable for dp/dn.
REQ-011 SHALL have port busy, output, 1, high from packet start until the EOP J bit completes.
REQ-012 SHALL have port underrun, output, 1, a one-cycle pulse when a byte is needed and tx_valid is low.

Function
REQ-013 SHALL implement states IDLE, SYNC, DATA, EOP_SE0 and EOP_J.
REQ-014 SHALL derive a bit strobe from a counter: 0..CLKS_PER_BIT-1, wrapping; the counter restarts at 0 on leaving IDLE; line changes occur only on the strobe.
REQ-015 In IDLE SHALL hold oe=0, dp=1, dn=0 (J) and busy=0, and SHALL ignore tx_last.
REQ-016 SHALL, in IDLE with tx_valid=1, go to SYNC the next cycle with busy=1 and oe=1; the first byte is not accepted in this cycle.
REQ-017 SHALL transmit SYNC as data bits 0,0,0,0,0,0,0,1, giving line symbols K J K J K J K K from idle J.
REQ-018 SHALL encode NRZI: data 0 toggles the line state, data 1 holds it; J is dp=1,dn=0 and K is dp=0,dn=1.
REQ-019 SHALL count consecutive 1 data bits, starting in SYNC. After the sixth 1 it SHALL insert one stuffed 0 (a toggle) before the next bit and reset the count. Stuffing SHALL apply across byte boundaries and SYNC.
REQ-020 SHALL assert tx_ready for exactly one cycle when the shifter needs a new byte: during the last bit time of SYNC or of a non-last byte, one cycle before the next bit strobe. A byte SHALL be captured only with tx_valid=1.
REQ-021 SHALL go to EOP_SE0 after the final bit of a byte accepted with tx_last=1, plus any pending stuff bit.
REQ-022 SHALL, when a byte is needed and tx_valid=0, pulse underrun and go to EOP_SE0 after any pending stuff bit.
REQ-023 In EOP_SE0 SHALL drive dp=0, dn=0 for 2 bit times, then J for 1 bit time in EOP_J, then return to IDLE with oe=0 and busy=0.
REQ-024 SHALL ignore tx_valid while busy, except at tx_ready cycles.
REQ-025 A packet of N bytes with no stuffing SHALL occupy exactly (8 + 8N + 3) * CLKS_PER_BIT cycles of oe=1.

Reset
REQ-026 SHALL, on reset_n low, asynchronously force IDLE, oe=0, dp=1, dn=0, tx_ready=0, busy=0, underrun=0, bit counter 0 and ones count 0.
REQ-027 SHALL, on reset mid-packet, drop oe immediately with no EOP, and SHALL restart from IDLE only after reset_n rises.

Structure
REQ-028 SHALL place the state encoding, SYNC_BYTE = 8'h80 and STUFF_LIMIT = 6 in a shared usb_pkg package.
REQ-029 SHALL use one sub-module, usb_nrzi_stuffer, which takes a bit-plus-strobe input, produces the line state and a stall when stuffing, and is reusable with the receive-side unstuffer.

Verification
REQ-030 SHALL verify single byte 0x00, last: line after SYNC toggles on all 8 bits (J K J K J K J K), then SE0 SE0 J, and oe=1 for 19 bit times.
REQ-031 SHALL verify byte 0xFF, last: the stuffed 0 is inserted after the 5th data bit (6 ones counting the SYNC final 1), and the packet lasts 20 bit times.
REQ-032 SHALL verify bytes 0x3F then 0xC0 (last): a stuff bit straddles the byte boundary and tx_ready pulses exactly twice.
REQ-033 SHALL verify tx_valid dropped after the first of two bytes: an underrun pulse, then EOP begins at the next bit boundary, then IDLE.
REQ-034 SHALL verify reset_n low in the middle of byte 2: oe=0 and dp=1,dn=0 in the same cycle, and a following packet transmits correctly.
REQ-035 SHALL verify CLKS_PER_BIT=8: all symbol durations double and the sequences are otherwise identical.
